fb_read_arbiter: RTL
====================

# fb_read_arbiter

Shares the single synchronous read port of the 160x120 RGB565 frame buffer between up to NUM_REQ pixel filters (fisheye zoom, mirror, and other coordinate-remapping filters). Each filter presents a read address and a request; the arbiter grants one per cycle, drives the BRAM port, and routes returned pixels back to the requester that issued them. Arbitration is round-robin, with an optional fixed-priority override for requester 0, which is reserved for the display-timed path.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- IMG_WIDTH, 160, frame width in pixels
- IMG_HEIGHT, 120, frame height in pixels
- ADDR_WIDTH, $clog2(IMG_WIDTH*IMG_HEIGHT) (15), frame buffer address width
- DATA_WIDTH, 16, pixel width (RGB565)
- RD_LATENCY, 1, BRAM cycles from fb_en to valid fb_data (1..3)
- PRIO0, 1, 1 = requester 0 has absolute priority; 0 = pure round-robin
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester read request; held with address until granted
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted req
- rvalid  out  NUM_REQ  one-hot, one-cycle pulse: rdata belongs to requester i
- rdata  out  DATA_WIDTH  returned pixel, registered
- fb_en  out  1  BRAM read enable, registered
- fb_addr  out  ADDR_WIDTH  BRAM read address, registered
- fb_data  in  DATA_WIDTH  BRAM read data, valid RD_LATENCY cycles after fb_en
- busy  out  1  high while any read is in flight (fb_en or pipeline stage valid)
- addr_err  out  1  sticky: a granted address was >= IMG_WIDTH*IMG_HEIGHT

## Operation
- Arbitration (combinational, every cycle): if PRIO0=1 and req[0]=1, winner = 0. Otherwise search req[] starting at rr_ptr, upward modulo NUM_REQ; first set bit wins. gnt = onehot(winner), or all zeros if no req or while reset is high.
- rr_ptr (register, width $clog2(NUM_REQ)): on a grant to requester w, rr_ptr <= (w+1) mod NUM_REQ. A priority grant to requester 0 under PRIO0=1 does not change rr_ptr. No grant leaves rr_ptr unchanged.
- Issue: on a grant edge, fb_en <= 1 and fb_addr <= req_addr[w]. If req_addr[w] >= IMG_WIDTH*IMG_HEIGHT, fb_addr <= IMG_WIDTH*IMG_HEIGHT-1 and addr_err <= 1. With no grant, fb_en <= 0 and fb_addr holds its value.
- Return tag pipeline: a shift register of RD_LATENCY+1 stages carries {valid, id}, aligned so that the tag reaches the output exactly when fb_data for that read is valid. On that edge, rdata <= fb_data and rvalid <= onehot(id). Otherwise rvalid <= 0 and rdata holds.
- Throughput: one grant per cycle, fully pipelined, no backpressure. Requesters must accept rvalid whenever it occurs.
- Requester contract: after gnt[i], the requester drops req or presents its next address on the following cycle. Each grant produces exactly one rvalid[i], returned in grant order.
- Starvation: with PRIO0=1, continuous req[0] starves all other requesters. This is intended, since the display path owns the port during active video.

## Timing
- Grant in cycle t: fb_en/fb_addr valid in t+1, fb_data valid in t+1+RD_LATENCY, rvalid/rdata valid in t+2+RD_LATENCY (3 cycles at RD_LATENCY=1).
- Back-to-back grants produce back-to-back rvalid pulses, one per cycle, in grant order.
- Reset (asynchronous, any cycle): rr_ptr=0, fb_en=0, fb_addr=0, rvalid=0, rdata=0, busy=0, addr_err=0, and all pipeline tags invalid. gnt is forced to 0 while reset is high.
- Reset mid-operation: in-flight reads are discarded and no rvalid is generated for them, even if fb_data later toggles. Arbitration resumes on the first edge after reset deasserts, with rr_ptr=0.
- Simultaneous events: a new grant and a returning rvalid in the same cycle are independent; both occur.
- busy = fb_en OR any valid pipeline tag OR any nonzero rvalid bit.

## Test plan
- Single request, PRIO0=0, RD_LATENCY=1: req[2]=1 with addr 9680 for one cycle, BRAM model returns 16'hF800 -> gnt[2] in cycle 0, fb_addr=9680 and fb_en=1 in cycle 1, rvalid[2]=1 and rdata=16'hF800 in cycle 3, rr_ptr=3.
- Round-robin fairness, PRIO0=0: all four req held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3, and 8 rvalid pulses in the same order, each with the data stored at its address.
- Priority override, PRIO0=1: req[0] and req[1] held high for 4 cycles, then req[0] dropped -> gnt[0] for 4 cycles, then gnt[1]. rr_ptr stays 0 until the grant to requester 1, then becomes 2.
- Out-of-range address: req[1] with addr 19200 -> fb_addr=19199, addr_err=1 and stays 1 until reset. rvalid[1] is still returned.
- Reset mid-flight, RD_LATENCY=3: grants in cycles 0 and 1, reset asserted in cycle 2 -> no rvalid pulses are ever produced, and all outputs are 0 immediately. After release, req[3] is granted, and rr_ptr goes from 0 to 0 (wrap from 3).
- Latency sweep: repeat the single-request case with RD_LATENCY=1,2,3 -> rvalid arrives at cycle 2+RD_LATENCY, and busy is high from cycle 1 through that cycle inclusive.

Source files
------------

// File: rtl/fb_read_arbiter.sv
// rtl/fb_read_arbiter.sv - round-robin / priority arbiter for the frame buffer read port
module fb_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT),
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1,
    parameter int PRIO0      = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          fb_en,
    output logic [ADDR_WIDTH-1:0]         fb_addr,
    input  logic [DATA_WIDTH-1:0]         fb_data,
    output logic                          busy,
    output logic                          addr_err
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
    // Tag stage 0 lines up with fb_en; stage RD_LATENCY lines up with valid fb_data.
    localparam int STAGES = RD_LATENCY + 1;

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]      win;
    logic                  win_vld;
    logic                  win_prio;
    logic [PTR_W:0]        idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_oor;

    logic                  fb_en_q;
    logic [ADDR_WIDTH-1:0] fb_addr_q;
    logic                  addr_err_q;
    logic [STAGES-1:0]     tag_vld_q;
    logic [PTR_W-1:0]      tag_id_q [STAGES];
    logic [NUM_REQ-1:0]    rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Pick the winner: requester 0 pre-empts when PRIO0 is set, else first request at/after rr_ptr.
    always_comb begin
        win      = '0;
        win_vld  = 1'b0;
        win_prio = 1'b0;
        idx      = '0;
        if ((PRIO0 != 0) && req[0]) begin
            win_vld  = 1'b1;
            win_prio = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
                if (idx >= (PTR_W+1)'(NUM_REQ)) begin
                    idx = idx - (PTR_W+1)'(NUM_REQ);
                end
                if (!win_vld && req[idx[PTR_W-1:0]]) begin
                    win_vld = 1'b1;
                    win     = idx[PTR_W-1:0];
                end
            end
        end
    end

    // Grant vector, address select with range clamp, and the round-robin pointer update.
    always_comb begin
        gnt = '0;
        if (win_vld && !reset) begin
            gnt[win] = 1'b1;
        end
        sel_addr = req_addr[int'(win) * ADDR_WIDTH +: ADDR_WIDTH];
        sel_oor  = ({1'b0, sel_addr} >= (ADDR_WIDTH+1)'(NPIX));
        rr_ptr_d = rr_ptr_q;
        if (win_vld && !win_prio) begin
            rr_ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end
    end

    // Issue the granted read to the BRAM and track out-of-range addresses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            fb_en_q    <= 1'b0;
            fb_addr_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            fb_en_q  <= win_vld;
            if (win_vld) begin
                fb_addr_q <= sel_oor ? ADDR_WIDTH'(NPIX - 1) : sel_addr;
                if (sel_oor) begin
                    addr_err_q <= 1'b1;
                end
            end
        end
    end

    // Carry {valid, id} alongside the read and steer returning data to its owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                tag_id_q[s] <= '0;
            end
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            tag_vld_q   <= {tag_vld_q[STAGES-2:0], win_vld};
            tag_id_q[0] <= win;
            for (int s = 1; s < STAGES; s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
            rvalid_q <= '0;
            if (tag_vld_q[STAGES-1]) begin
                rvalid_q[tag_id_q[STAGES-1]] <= 1'b1;
                rdata_q                      <= fb_data;
            end
        end
    end

    assign fb_en    = fb_en_q;
    assign fb_addr  = fb_addr_q;
    assign addr_err = addr_err_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign busy     = fb_en_q | (|tag_vld_q) | (|rvalid_q);

endmodule
